sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 96 +++++++++
 tb/tb_sum_accumulator.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Accumulates bursts of BURST adder results (sum plus carry-out) and reports
// the 2N-bit total and the carry count over a valid/ready handshake.
module sum_accumulator #(
    parameter int N     = 32,
    parameter int BURST = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_sum,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_total,
    output logic [15:0]      out_ovf
);

    localparam int ACC_W = 2 * N;
    localparam logic [15:0] LAST_CNT = 16'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        ovf_q, ovf_d;
    logic               accept;

    // rst gates in_ready so nothing can look accepted while reset is held.
    assign in_ready = (state_q == ACCUM) && en && !clr && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        acc_d = acc_q + ACC_W'({in_cout, in_sum});
        cnt_d = cnt_q + 16'd1;
        ovf_d = ovf_q + {15'd0, in_cout};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= '0;
        end else if (clr) begin
            state_q <= en ? ACCUM : IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= REPORT;
                        end
                    end else if (!en && cnt_q == 16'd0) begin
                        state_q <= IDLE;
                    end
                end
                REPORT: begin
                    // Results stay frozen in the registers until the handshake.
                    if (out_ready) begin
                        state_q <= ACCUM;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = (state_q == REPORT);
    assign out_total = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: reset, bursts, carry, backpressure,
// clr and rst behaviour with hand-computed totals.
module tb_sum_accumulator;

    localparam int N     = 32;
    localparam int BURST = 8;

    logic              clk = 1'b0;
    logic              rst, en, clr, in_valid, in_cout, out_ready;
    logic [N-1:0]      in_sum;
    logic              in_ready, out_valid;
    logic [2*N-1:0]    out_total;
    logic [15:0]       out_ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    sum_accumulator #(.N(N), .BURST(BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_total (out_total),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // Inputs change just after a falling edge; one tick spans one rising edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic accept_n(input int n, input logic [N-1:0] sum, input logic cout);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sum   = sum;
            in_cout  = cout;
            #1;
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL accept_ready[%0d]: in_ready=%b expected 1", i, in_ready);
            end
            tick();
            if (i < n - 1) begin
                tests_run++;
                if (out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL early_valid[%0d]: out_valid=%b expected 0", i, out_valid);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; clr = 1'b0; in_valid = 1'b1;
        in_sum = 32'd1000; in_cout = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_total !== 64'd0 || out_ovf !== 16'd0) begin
                tests_failed++;
                $display("FAIL reset[%0d]: rdy=%b vld=%b total=%0h ovf=%0d expected 0/0/0/0",
                         c, in_ready, out_valid, out_total, out_ovf);
            end
        end
        rst = 1'b0; en = 1'b0; in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_total !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_noacc: total=%0h expected 0", out_total);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_basic_burst();
        en = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_sum = 32'd1000; in_cout = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_ready: in_ready=%b expected 0", in_ready);
        end
        tick();
        accept_n(8, 32'd1000, 1'b0);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_total !== 64'd8000 || out_ovf !== 16'd0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_report: vld=%b total=%0d ovf=%0d rdy=%b expected 1/8000/0/0",
                     out_valid, out_total, out_ovf, in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_total !== 64'd0 || out_ovf !== 16'd0) begin
            tests_failed++;
            $display("FAIL basic_handshake: vld=%b total=%0d ovf=%0d expected 0/0/0",
                     out_valid, out_total, out_ovf);
        end
        $display("[TB] basic burst total=%0d", 8000);
    endtask

    task automatic test_carry();
        accept_n(8, 32'hFFFF_FFFF, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || out_total !== 64'h0000_000F_FFFF_FFF8 || out_ovf !== 16'd8) begin
            tests_failed++;
            $display("FAIL carry: vld=%b total=%h ovf=%0d expected 1/0000000ffffffff8/8",
                     out_valid, out_total, out_ovf);
        end
        tick();
        $display("[TB] carry burst checked");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            accept_n(1, 32'(i), 1'(i % 2));
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_sum = 32'd100; in_cout = 1'b0;
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_total !== 64'h0000_0004_0000_0024 ||
                out_ovf !== 16'd4 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure[%0d]: vld=%b total=%h ovf=%0d rdy=%b expected 1/0000000400000024/4/0",
                         c, out_valid, out_total, out_ovf, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_total !== 64'd0) begin
            tests_failed++;
            $display("FAIL bp_handshake: vld=%b total=%0d expected 0/0", out_valid, out_total);
        end
        accept_n(8, 32'd100, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_total !== 64'd800) begin
            tests_failed++;
            $display("FAIL bp_next_burst: vld=%b total=%0d expected 1/800", out_valid, out_total);
        end
        tick();
        $display("[TB] backpressure checked");
    endtask

    task automatic test_clr_mid_burst();
        accept_n(3, 32'd5, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_sum = 32'd5;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_ready: in_ready=%b expected 0", in_ready);
        end
        tick();
        clr = 1'b0; in_valid = 1'b0;
        tests_run++;
        if (out_total !== 64'd0) begin
            tests_failed++;
            $display("FAIL clr_cleared: total=%0d expected 0", out_total);
        end
        accept_n(8, 32'd2, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_total !== 64'd16 || out_ovf !== 16'd0) begin
            tests_failed++;
            $display("FAIL clr_report: vld=%b total=%0d ovf=%0d expected 1/16/0",
                     out_valid, out_total, out_ovf);
        end
        tick();
        $display("[TB] clr mid-burst checked");
    endtask

    task automatic test_en_low();
        accept_n(2, 32'd10, 1'b0);
        en = 1'b0; in_valid = 1'b1; in_sum = 32'd10;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (in_ready !== 1'b0 || out_total !== 64'd20) begin
                tests_failed++;
                $display("FAIL en_low_hold[%0d]: rdy=%b total=%0d expected 0/20", c, in_ready, out_total);
            end
            tick();
        end
        en = 1'b1;
        accept_n(6, 32'd10, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_total !== 64'd80) begin
            tests_failed++;
            $display("FAIL en_low_report: vld=%b total=%0d expected 1/80", out_valid, out_total);
        end
        tick();
        en = 1'b0;
        tick();
        en = 1'b1; in_valid = 1'b1; in_sum = 32'd1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_low_idle: in_ready=%b expected 0", in_ready);
        end
        in_valid = 1'b0;
        tick();
        $display("[TB] en low checked");
    endtask

    task automatic test_clr_in_report();
        accept_n(8, 32'd3, 1'b1);
        clr = 1'b1; en = 1'b0; out_ready = 1'b0;
        tick();
        clr = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_total !== 64'd0 || out_ovf !== 16'd0) begin
            tests_failed++;
            $display("FAIL clr_report_drop: vld=%b total=%0d ovf=%0d expected 0/0/0",
                     out_valid, out_total, out_ovf);
        end
        en = 1'b1; out_ready = 1'b1;
        tick();
        $display("[TB] clr in report checked");
    endtask

    task automatic test_rst_in_report();
        accept_n(8, 32'd7, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_total !== 64'd56) begin
            tests_failed++;
            $display("FAIL rst_pre_report: vld=%b total=%0d expected 1/56", out_valid, out_total);
        end
        rst = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_total !== 64'd0 || out_ovf !== 16'd0) begin
            tests_failed++;
            $display("FAIL rst_report: vld=%b total=%0d ovf=%0d expected 0/0/0",
                     out_valid, out_total, out_ovf);
        end
        in_valid = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_idle: in_ready=%b expected 0", in_ready);
        end
        in_valid = 1'b0;
        tick();
        $display("[TB] rst in report checked");
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_carry();
        test_backpressure();
        test_clr_mid_burst();
        test_en_low();
        test_clr_in_report();
        test_rst_in_report();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
